// File: rtl/mcpu_core_stage_fetch_buf_pkg.sv
// Shared definitions for the buffered core fetch stage.
//   - default widths for virtual PC, physical page, in-page offset and I$ bundle
//   - fetch_entry_t: one buffered fetch {vpc, data} at the default widths
//   - cnt_w(): width of a counter that must hold 0..depth inclusive
package mcpu_core_stage_fetch_buf_pkg;

    localparam int VPC_W_DEF  = 28;
    localparam int PAGE_W_DEF = 20;
    localparam int OFF_W_DEF  = 8;
    localparam int DATA_W_DEF = 128;
    localparam int DEPTH_DEF  = 4;

    typedef struct packed {
        logic [VPC_W_DEF-1:0]  vpc;
        logic [DATA_W_DEF-1:0] data;
    } fetch_entry_t;

    // Counters run 0..depth inclusive, so they need one value more than a pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mcpu_core_stage_fetch_buf_if.sv
// Fetch <-> I$ request/response bus.
//   master (fetch side): drives f2ic_valid/f2ic_paddr, receives ready and in-order responses
//   slave  (I$ side):    the mirror image
interface mcpu_core_stage_fetch_buf_if #(
    parameter int VPC_W  = 28,
    parameter int DATA_W = 128
);
    logic              f2ic_valid;
    logic [VPC_W-1:0]  f2ic_paddr;
    logic              ic2f_ready;
    logic              ic2f_rvalid;
    logic [DATA_W-1:0] ic2f_rdata;

    modport master (
        output f2ic_valid, f2ic_paddr,
        input  ic2f_ready, ic2f_rvalid, ic2f_rdata
    );

    modport slave (
        input  f2ic_valid, f2ic_paddr,
        output ic2f_ready, ic2f_rvalid, ic2f_rdata
    );
endinterface

// File: rtl/mcpu_core_fetch_ring.sv
// DEPTH-entry ring of fetch bundles with separate alloc / fill / head pointers.
//   alloc_en + alloc_vpc : reserve entry at alloc pointer, record its VPC, mark unfilled
//   fill_en  + fill_data : write the response bundle into the oldest unfilled entry
//   pop_en               : retire the head entry
//   clear                : drop everything (pointers and filled bits to zero)
//   head_*               : view of the head entry, straight from registered state
// Occupancy is tracked by the caller; pointers alone cannot tell full from empty.
module mcpu_core_fetch_ring
    import mcpu_core_stage_fetch_buf_pkg::*;
#(
    parameter int VPC_W  = VPC_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              clear,
    input  logic              alloc_en,
    input  logic [VPC_W-1:0]  alloc_vpc,
    input  logic              fill_en,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              pop_en,
    output logic              head_filled,
    output logic [VPC_W-1:0]  head_vpc,
    output logic [DATA_W-1:0] head_data
);
    localparam int PTR_W = $clog2(DEPTH);

    // Payload storage is deliberately not reset; filled bits qualify it.
    logic [VPC_W-1:0]  vpc_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0] fill_ptr_q,  fill_ptr_d;
    logic [PTR_W-1:0] head_ptr_q,  head_ptr_d;

    // DEPTH is a power of two, so the +1 wraps on its own.
    always_comb begin
        alloc_ptr_d = alloc_ptr_q + PTR_W'(alloc_en);
        fill_ptr_d  = fill_ptr_q  + PTR_W'(fill_en);
        head_ptr_d  = head_ptr_q  + PTR_W'(pop_en);
        if (clear) begin
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
        end
    end

    // Alloc and fill never target the same entry (fill only walks allocated,
    // unfilled entries), so their order here is immaterial.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
            assign filled_d[gi] = clear                                      ? 1'b0 :
                                  (alloc_en && alloc_ptr_q == PTR_W'(gi))    ? 1'b0 :
                                  (fill_en  && fill_ptr_q  == PTR_W'(gi))    ? 1'b1 :
                                                                               filled_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            filled_q    <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
        end else begin
            filled_q    <= filled_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en) vpc_mem[alloc_ptr_q] <= alloc_vpc;
        if (fill_en)  data_mem[fill_ptr_q] <= fill_data;
    end

    assign head_filled = filled_q[head_ptr_q];
    assign head_vpc    = vpc_mem[head_ptr_q];
    assign head_data   = data_mem[head_ptr_q];

endmodule

// File: rtl/mcpu_core_stage_fetch_buf.sv
// Buffered core fetch stage: issues translated fetches to the I$, keeps up to
// DEPTH of them (in flight or returned) in a ring, and hands them to decode in order.
//   clkrst_core_clk/rst      : clock, synchronous active-high reset
//   f_valid, ft2f_in_*       : translated fetch from the TLB; ft2f_progress = accepted
//   ic_bus (master)          : I$ request (valid/ready) and in-order response
//   f2d_*                    : head bundle to decode, consumed on f2d_valid & f2d_progress
//   pipe_flush               : drop buffered entries; in-flight responses get squashed
//   f_occupancy              : allocated entries
module mcpu_core_stage_fetch_buf
    import mcpu_core_stage_fetch_buf_pkg::*;
#(
    parameter int VPC_W  = VPC_W_DEF,
    parameter int PAGE_W = PAGE_W_DEF,
    parameter int OFF_W  = OFF_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                         clkrst_core_clk,
    input  logic                         clkrst_core_rst,
    input  logic                         f_valid,
    input  logic [PAGE_W-1:0]            ft2f_in_physpage,
    input  logic [VPC_W-1:0]             ft2f_in_virtpc,
    output logic                         ft2f_progress,
    mcpu_core_stage_fetch_buf_if.master  ic_bus,
    output logic                         f2d_valid,
    output logic [VPC_W-1:0]             f2d_out_virtpc,
    output logic [DATA_W-1:0]            f2d_out_data,
    input  logic                         f2d_progress,
    input  logic                         pipe_flush,
    output logic [$clog2(DEPTH+1)-1:0]   f_occupancy
);
    localparam int CNT_W = cnt_w(DEPTH);

    // alloc_cnt:    entries holding a live fetch (in flight or filled)
    // inflight_cnt: live fetches still waiting for their response
    // squash_cnt:   responses still owed for fetches killed by a flush
    logic [CNT_W-1:0] alloc_cnt_q,    alloc_cnt_d;
    logic [CNT_W-1:0] inflight_cnt_q, inflight_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q,   squash_cnt_d;

    logic credit, issue_valid, fire, rsp_squash, rsp_fill, pop, head_filled;

    always_comb begin
        // Squashed responses still occupy I$ slots, so they consume credit too.
        credit      = ({1'b0, alloc_cnt_q} + {1'b0, squash_cnt_q}) < (CNT_W+1)'(DEPTH);
        issue_valid = f_valid & ~pipe_flush & ~clkrst_core_rst & credit;
        fire        = issue_valid & ic_bus.ic2f_ready;
        rsp_squash  = ic_bus.ic2f_rvalid & (squash_cnt_q != '0);
        // A response with nothing owed is a protocol error and is dropped.
        rsp_fill    = ic_bus.ic2f_rvalid & (squash_cnt_q == '0) & (inflight_cnt_q != '0);
        pop         = f2d_valid & f2d_progress & ~pipe_flush;

        if (pipe_flush) begin
            // Everything still in flight becomes owed-and-discarded, minus the
            // response (if any) landing this very cycle.
            alloc_cnt_d    = '0;
            inflight_cnt_d = '0;
            squash_cnt_d   = squash_cnt_q + inflight_cnt_q - CNT_W'(rsp_squash | rsp_fill);
        end else begin
            alloc_cnt_d    = alloc_cnt_q + CNT_W'(fire) - CNT_W'(pop);
            inflight_cnt_d = inflight_cnt_q + CNT_W'(fire) - CNT_W'(rsp_fill);
            squash_cnt_d   = squash_cnt_q - CNT_W'(rsp_squash);
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            alloc_cnt_q    <= '0;
            inflight_cnt_q <= '0;
            squash_cnt_q   <= '0;
        end else begin
            alloc_cnt_q    <= alloc_cnt_d;
            inflight_cnt_q <= inflight_cnt_d;
            squash_cnt_q   <= squash_cnt_d;
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (!clkrst_core_rst && ic_bus.ic2f_rvalid) begin
            assert (squash_cnt_q != '0 || inflight_cnt_q != '0)
                else $error("fetch_buf: I$ response with no request outstanding");
        end
    end

    mcpu_core_fetch_ring #(
        .VPC_W  (VPC_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ring (
        .clk         (clkrst_core_clk),
        .srst        (clkrst_core_rst),
        .clear       (pipe_flush),
        .alloc_en    (fire),
        .alloc_vpc   (ft2f_in_virtpc),
        .fill_en     (rsp_fill & ~pipe_flush),
        .fill_data   (ic_bus.ic2f_rdata),
        .pop_en      (pop),
        .head_filled (head_filled),
        .head_vpc    (f2d_out_virtpc),
        .head_data   (f2d_out_data)
    );

    assign ic_bus.f2ic_valid = issue_valid;
    assign ic_bus.f2ic_paddr = {ft2f_in_physpage, ft2f_in_virtpc[OFF_W-1:0]};
    assign ft2f_progress     = fire;
    // A stale filled bit can sit under head only when the ring is empty.
    assign f2d_valid         = head_filled & (alloc_cnt_q != '0);
    assign f_occupancy       = alloc_cnt_q;

endmodule

// File: tb/tb_mcpu_core_stage_fetch_buf.sv
// Directed bench for the buffered fetch stage: a cycle-vector table for the
// single-fetch and fill-to-full cases, then hand sequences for streaming,
// flush, flush-with-response and mid-stream reset.
module tb_mcpu_core_stage_fetch_buf;
    import mcpu_core_stage_fetch_buf_pkg::*;

    localparam int VPC_W = 28, PAGE_W = 20, OFF_W = 8, DATA_W = 128, DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              f_valid = 1'b0;
    logic [PAGE_W-1:0] page = '0;
    logic [VPC_W-1:0]  vpc = '0;
    logic              ft2f_progress;
    logic              f2d_valid;
    logic [VPC_W-1:0]  f2d_out_virtpc;
    logic [DATA_W-1:0] f2d_out_data;
    logic              f2d_progress = 1'b0;
    logic              pipe_flush = 1'b0;
    logic [2:0]        f_occupancy;

    always #5 clk = ~clk;

    mcpu_core_stage_fetch_buf_if #(.VPC_W(VPC_W), .DATA_W(DATA_W)) ic_bus ();

    mcpu_core_stage_fetch_buf #(
        .VPC_W(VPC_W), .PAGE_W(PAGE_W), .OFF_W(OFF_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clkrst_core_clk  (clk),
        .clkrst_core_rst  (rst),
        .f_valid          (f_valid),
        .ft2f_in_physpage (page),
        .ft2f_in_virtpc   (vpc),
        .ft2f_progress    (ft2f_progress),
        .ic_bus           (ic_bus),
        .f2d_valid        (f2d_valid),
        .f2d_out_virtpc   (f2d_out_virtpc),
        .f2d_out_data     (f2d_out_data),
        .f2d_progress     (f2d_progress),
        .pipe_flush       (pipe_flush),
        .f_occupancy      (f_occupancy)
    );

    typedef struct {
        logic rst, fv;
        logic [PAGE_W-1:0] pg;
        logic [VPC_W-1:0]  pc;
        logic rdy, rv;
        logic [DATA_W-1:0] rd;
        logic pr, fl;
        logic e_prog, e_icv;
        logic [VPC_W-1:0]  e_paddr;
        logic e_dv, chk_head;
        logic [VPC_W-1:0]  e_vpc;
        logic [DATA_W-1:0] e_data;
        logic [2:0] e_occ;
    } vec_t;

    vec_t vq[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] junk = {4{32'hDEAD_BEEF}};

    function automatic logic [DATA_W-1:0] data_of(input logic [VPC_W-1:0] v);
        return {4{4'hD, v}};
    endfunction

    function automatic logic [DATA_W-1:0] ic_data(input logic [VPC_W-1:0] p);
        return {4{4'hA, p}};
    endfunction

    function automatic vec_t mk(input logic r, fv, input logic [PAGE_W-1:0] pg,
                                input logic [VPC_W-1:0] pc, input logic rdy, rv,
                                input logic [DATA_W-1:0] rd, input logic pr, fl,
                                input logic e_prog, e_icv, input logic [VPC_W-1:0] e_paddr,
                                input logic e_dv, chk_head, input logic [VPC_W-1:0] e_vpc,
                                input logic [DATA_W-1:0] e_data, input logic [2:0] e_occ);
        vec_t v;
        v.rst = r; v.fv = fv; v.pg = pg; v.pc = pc; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.pr = pr; v.fl = fl; v.e_prog = e_prog; v.e_icv = e_icv; v.e_paddr = e_paddr;
        v.e_dv = e_dv; v.chk_head = chk_head; v.e_vpc = e_vpc; v.e_data = e_data;
        v.e_occ = e_occ;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply inputs just after a rising edge, return at the following falling edge.
    task automatic drive(input logic r, fv, input logic [PAGE_W-1:0] pg,
                         input logic [VPC_W-1:0] pc, input logic rdy, rv,
                         input logic [DATA_W-1:0] rd, input logic pr, fl);
        @(posedge clk);
        #1;
        rst = r; f_valid = fv; page = pg; vpc = pc;
        ic_bus.ic2f_ready = rdy; ic_bus.ic2f_rvalid = rv; ic_bus.ic2f_rdata = rd;
        f2d_progress = pr; pipe_flush = fl;
        @(negedge clk);
    endtask

    task automatic idle(input logic rv, input logic [DATA_W-1:0] rd, input logic pr);
        drive(1'b0, 1'b0, '0, '0, 1'b1, rv, rd, pr, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [VPC_W-1:0] pq[$];
        logic [VPC_W-1:0] pc;
        logic [VPC_W-1:0] ev;
        logic [DATA_W-1:0] rd;
        logic rv, fv;
        int issued, recv, first_c, last_c;

        ic_bus.ic2f_ready = 1'b0; ic_bus.ic2f_rvalid = 1'b0; ic_bus.ic2f_rdata = '0;

        // ---------------- table: single fetch, then fill to full ----------------
        vq.push_back(mk(1,1,20'h00ABC,28'h12,1,0,'0,0,0, 0,0,28'h00ABC12, 0,0,'0,'0,0));
        vq.push_back(mk(0,1,20'h00ABC,28'h12,1,0,'0,0,0, 1,1,28'h00ABC12, 0,0,'0,'0,0));
        vq.push_back(mk(0,0,20'h00ABC,28'h12,1,0,'0,0,0, 0,0,28'h00ABC12, 0,0,'0,'0,1));
        vq.push_back(mk(0,0,20'h00ABC,28'h12,1,0,'0,0,0, 0,0,28'h00ABC12, 0,0,'0,'0,1));
        vq.push_back(mk(0,0,20'h00ABC,28'h12,1,1,data_of(28'h12),0,0, 0,0,28'h00ABC12, 0,0,'0,'0,1));
        vq.push_back(mk(0,0,20'h00ABC,28'h12,1,0,'0,0,0, 0,0,28'h00ABC12, 1,1,28'h12,data_of(28'h12),1));
        vq.push_back(mk(0,0,20'h00ABC,28'h12,1,0,'0,1,0, 0,0,28'h00ABC12, 1,1,28'h12,data_of(28'h12),1));
        vq.push_back(mk(0,0,20'h00ABC,28'h12,1,0,'0,0,0, 0,0,28'h00ABC12, 0,0,'0,'0,0));
        vq.push_back(mk(0,1,20'h00001,28'h20,1,0,'0,0,0, 1,1,28'h0000120, 0,0,'0,'0,0));
        vq.push_back(mk(0,1,20'h00001,28'h21,1,0,'0,0,0, 1,1,28'h0000121, 0,0,'0,'0,1));
        vq.push_back(mk(0,1,20'h00001,28'h22,1,0,'0,0,0, 1,1,28'h0000122, 0,0,'0,'0,2));
        vq.push_back(mk(0,1,20'h00001,28'h23,1,0,'0,0,0, 1,1,28'h0000123, 0,0,'0,'0,3));
        vq.push_back(mk(0,1,20'h00001,28'h24,1,1,data_of(28'h20),0,0, 0,0,28'h0000124, 0,0,'0,'0,4));
        vq.push_back(mk(0,1,20'h00001,28'h24,1,0,'0,1,0, 0,0,28'h0000124, 1,1,28'h20,data_of(28'h20),4));
        vq.push_back(mk(0,1,20'h00001,28'h24,1,0,'0,0,0, 1,1,28'h0000124, 0,0,'0,'0,3));
        vq.push_back(mk(0,0,20'h00001,28'h24,1,0,'0,0,0, 0,0,28'h0000124, 0,0,'0,'0,4));

        do_reset();
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].fv, vq[i].pg, vq[i].pc, vq[i].rdy, vq[i].rv,
                  vq[i].rd, vq[i].pr, vq[i].fl);
            chk($sformatf("vec%0d_progress", i), 128'(ft2f_progress), 128'(vq[i].e_prog));
            chk($sformatf("vec%0d_icvalid", i), 128'(ic_bus.f2ic_valid), 128'(vq[i].e_icv));
            chk($sformatf("vec%0d_paddr", i), 128'(ic_bus.f2ic_paddr), 128'(vq[i].e_paddr));
            chk($sformatf("vec%0d_f2dvalid", i), 128'(f2d_valid), 128'(vq[i].e_dv));
            chk($sformatf("vec%0d_occ", i), 128'(f_occupancy), 128'(vq[i].e_occ));
            if (vq[i].chk_head) begin
                chk($sformatf("vec%0d_vpc", i), 128'(f2d_out_virtpc), 128'(vq[i].e_vpc));
                chk($sformatf("vec%0d_data", i), f2d_out_data, vq[i].e_data);
            end
            $display("vec %0d: icv=%0b prog=%0b dv=%0b occ=%0d", i, ic_bus.f2ic_valid,
                     ft2f_progress, f2d_valid, f_occupancy);
        end

        // ---------------- streaming, 1-cycle I$ latency, decode always ready ----------------
        do_reset();
        issued = 0; recv = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40; c++) begin
            rv = (pq.size() > 0);
            rd = rv ? ic_data(pq.pop_front()) : '0;
            fv = (issued < 20);
            pc = 28'h100 + 28'(issued);
            drive(1'b0, fv, 20'h00005, pc, 1'b1, rv, rd, 1'b1, 1'b0);
            if (fv) chk("stream_icvalid", 128'(ic_bus.f2ic_valid), 128'(1));
            if (ic_bus.f2ic_valid && ic_bus.ic2f_ready) begin
                pq.push_back(ic_bus.f2ic_paddr);
                issued++;
            end
            if (f2d_valid) begin
                ev = 28'h100 + 28'(recv);
                chk("stream_vpc", 128'(f2d_out_virtpc), 128'(ev));
                chk("stream_data", f2d_out_data, ic_data({20'h00005, ev[7:0]}));
                $display("stream cycle %0d: vpc=%0h", c, f2d_out_virtpc);
                if (first_c < 0) first_c = c;
                last_c = c;
                recv++;
            end
        end
        chk("stream_count", 128'(recv), 128'(20));
        chk("stream_rate", 128'(last_c - first_c + 1), 128'(20));

        // ---------------- flush with 3 in flight and 1 filled ----------------
        do_reset();
        drive(0,1,20'h7,28'h40,1,0,'0,0,0); chk("fl_icv0", 128'(ic_bus.f2ic_valid), 128'(1));
        drive(0,1,20'h7,28'h41,1,1,data_of(28'h40),0,0);
        drive(0,1,20'h7,28'h42,1,0,'0,0,0); chk("fl_head", 128'(f2d_out_virtpc), 128'(28'h40));
        drive(0,1,20'h7,28'h43,1,0,'0,0,0); chk("fl_occ3", 128'(f_occupancy), 128'(3));
        drive(0,1,20'h7,28'h44,1,0,'0,0,1);
        chk("fl_noissue", 128'(ic_bus.f2ic_valid), 128'(0));
        chk("fl_dv_pre", 128'(f2d_valid), 128'(1));
        $display("flush cycle: occ=%0d dv=%0b", f_occupancy, f2d_valid);
        drive(0,1,20'h7,28'h50,1,0,'0,0,0);
        chk("fl_dv_post", 128'(f2d_valid), 128'(0));
        chk("fl_squash3", 128'(dut.squash_cnt_q), 128'(3));
        chk("fl_occ0", 128'(f_occupancy), 128'(0));
        chk("fl_reissue", 128'(ic_bus.f2ic_valid), 128'(1));
        drive(0,1,20'h7,28'h51,1,1,junk,1,0);
        chk("fl_nocredit", 128'(ic_bus.f2ic_valid), 128'(0));
        chk("fl_dv_j1", 128'(f2d_valid), 128'(0));
        idle(1, junk, 1); chk("fl_squash2", 128'(dut.squash_cnt_q), 128'(2));
        chk("fl_dv_j2", 128'(f2d_valid), 128'(0));
        idle(1, junk, 1); chk("fl_squash1", 128'(dut.squash_cnt_q), 128'(1));
        chk("fl_dv_j3", 128'(f2d_valid), 128'(0));
        idle(1, data_of(28'h50), 1); chk("fl_squash0", 128'(dut.squash_cnt_q), 128'(0));
        chk("fl_dv_b", 128'(f2d_valid), 128'(0));
        idle(0, '0, 1);
        chk("fl_new_dv", 128'(f2d_valid), 128'(1));
        chk("fl_new_vpc", 128'(f2d_out_virtpc), 128'(28'h50));
        chk("fl_new_data", f2d_out_data, data_of(28'h50));
        chk("fl_new_occ", 128'(f_occupancy), 128'(1));
        $display("post-flush fetch: vpc=%0h", f2d_out_virtpc);
        idle(0, '0, 0);
        chk("fl_drained", 128'(f2d_valid), 128'(0));

        // ---------------- flush together with a response and a dequeue ----------------
        do_reset();
        drive(0,1,20'h7,28'h60,1,0,'0,0,0);
        drive(0,1,20'h7,28'h61,1,1,data_of(28'h60),0,0);
        drive(0,1,20'h7,28'h62,1,0,'0,0,0);
        drive(0,0,20'h7,28'h62,1,1,junk,1,1);
        chk("fr_dv_pre", 128'(f2d_valid), 128'(1));
        chk("fr_occ_pre", 128'(f_occupancy), 128'(3));
        idle(1, junk, 1);
        chk("fr_squash1", 128'(dut.squash_cnt_q), 128'(1));
        chk("fr_dv_post", 128'(f2d_valid), 128'(0));
        chk("fr_occ0", 128'(f_occupancy), 128'(0));
        drive(0,1,20'h7,28'h68,1,0,'0,0,0);
        chk("fr_squash0", 128'(dut.squash_cnt_q), 128'(0));
        chk("fr_issue", 128'(ft2f_progress), 128'(1));
        idle(1, data_of(28'h68), 0);
        chk("fr_dv_lat", 128'(f2d_valid), 128'(0));
        idle(0, '0, 1);
        chk("fr_dv", 128'(f2d_valid), 128'(1));
        chk("fr_vpc", 128'(f2d_out_virtpc), 128'(28'h68));
        chk("fr_data", f2d_out_data, data_of(28'h68));
        $display("flush+rsp: delivered vpc=%0h", f2d_out_virtpc);

        // ---------------- reset mid-stream with 2 filled ----------------
        do_reset();
        drive(0,1,20'h9,28'h70,1,0,'0,0,0);
        drive(0,1,20'h9,28'h71,1,1,data_of(28'h70),0,0);
        drive(0,1,20'h9,28'h72,1,1,data_of(28'h71),0,0);
        drive(1,1,20'h9,28'h73,1,0,'0,0,0);
        chk("rs_icv_in_rst", 128'(ic_bus.f2ic_valid), 128'(0));
        chk("rs_prog_in_rst", 128'(ft2f_progress), 128'(0));
        chk("rs_dv_pre", 128'(f2d_valid), 128'(1));
        chk("rs_occ_pre", 128'(f_occupancy), 128'(3));
        drive(0,0,20'h9,28'h73,1,0,'0,0,0);
        chk("rs_dv", 128'(f2d_valid), 128'(0));
        chk("rs_occ", 128'(f_occupancy), 128'(0));
        chk("rs_icv", 128'(ic_bus.f2ic_valid), 128'(0));
        chk("rs_squash", 128'(dut.squash_cnt_q), 128'(0));
        drive(0,1,20'h9,28'h78,1,0,'0,0,0);
        chk("rs_fire", 128'(ft2f_progress), 128'(1));
        chk("rs_paddr", 128'(ic_bus.f2ic_paddr), 128'(28'h0000978));
        idle(1, data_of(28'h78), 0);
        idle(0, '0, 1);
        chk("rs_dv_new", 128'(f2d_valid), 128'(1));
        chk("rs_vpc_new", 128'(f2d_out_virtpc), 128'(28'h78));
        chk("rs_data_new", f2d_out_data, data_of(28'h78));
        $display("post-reset fetch: vpc=%0h", f2d_out_virtpc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
